// File: rtl/aes128_decry_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, with a cached round-key file
// so that back-to-back blocks under the same key skip key expansion.
module aes128_decry_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cypher,
  input  logic [127:0] input_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain,
  output logic         busy
);

  // state  | meaning
  // IDLE   | waiting for a block, in_ready high
  // KEXP   | expanding rk[1..10] from rk[0], one per cycle
  // INIT   | initial AddRoundKey with rk[10]
  // ROUND  | inverse rounds, counter 9 down to 0
  // DONE   | plaintext held on plain until consumed
  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_DONE} state_t;

  state_t       state;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [127:0] rk [0:10];
  logic         kvalid;
  logic [3:0]   cnt;
  logic [127:0] key_nxt;
  logic [127:0] round_nxt;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(i), 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte k sits at row k%4, column k/4; row r is rotated right by r columns.
  function automatic logic [127:0] dec_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + 4 - r) % 4) + r;
        t[127 - 8 * (4 * c + r) -: 8] = inv_sbox(d[127 - 8 * src -: 8]);
      end
    end
    t = t ^ k;
    if (!last) begin
      for (int c = 0; c < 4; c++) t[127 - 32 * c -: 32] = inv_mix_col(t[127 - 32 * c -: 32]);
    end
    return t;
  endfunction

  assign key_nxt   = key_step(rk[cnt - 4'd1], cnt);
  assign round_nxt = dec_round(data_q, rk[cnt], cnt == 4'd0);
  assign plain     = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      data_q    <= '0;
      key_q     <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
      kvalid    <= 1'b0;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q   <= cypher;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (kvalid && (input_key == key_q)) begin
              state <= S_INIT;
            end else begin
              key_q  <= input_key;
              rk[0]  <= input_key;
              kvalid <= 1'b0;
              cnt    <= 4'd1;
              state  <= S_KEXP;
            end
          end
        end
        S_KEXP: begin
          rk[cnt] <= key_nxt;
          if (cnt == 4'd10) begin
            kvalid <= 1'b1;
            state  <= S_INIT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_INIT: begin
          data_q <= data_q ^ rk[10];
          cnt    <= 4'd9;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          data_q <= round_nxt;
          if (cnt == 4'd0) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decry_iter.sv
// Scoreboard bench for aes128_decry_iter: known-answer vectors plus a forward AES model
// to produce extra ciphertexts, with latency, backpressure and reset checks.
module tb_aes128_decry_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cypher;
  logic [127:0] input_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    time          t_acc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] sbt [256];

  aes128_decry_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cypher    (cypher),
    .input_key (input_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain     (plain),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Walks generator 3 and its inverse to fill the forward S-box table.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbt[p] = x ^ 8'h63;
    end
    sbt[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbt[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4 * rd + k / 4][31 - 8 * (k % 4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
    return res;
  endfunction

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send(input logic [127:0] key, input logic [127:0] ct,
                      input logic [127:0] pt, input int lat);
    exp_t e;
    int   n;
    in_valid  = 1'b1;
    cypher    = ct;
    input_key = key;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.pt    = pt;
    e.lat   = lat;
    e.t_acc = $time;
    sb.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    cypher    = {$urandom, $urandom, $urandom, $urandom};
    input_key = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_accept", {127'd0, busy}, 128'd1);
    chk("in_ready_after_accept", {127'd0, in_ready}, 128'd0);
  endtask

  task automatic collect(input int hold);
    exp_t         e;
    int           n;
    int           lat;
    logic [127:0] p0;
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 128'd0, 128'd1);
      return;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      chk("out_timeout", 128'd0, 128'd1);
      out_ready = 1'b1;
      return;
    end
    lat = int'(($time - e.t_acc - 5) / 10);
    chk("latency", 128'(lat), 128'(e.lat));
    chk("plain", plain, e.pt);
    if (hold > 0) begin
      p0 = plain;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_plain", plain, p0);
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("done_out_valid", {127'd0, out_valid}, 128'd0);
    chk("done_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_plain"}, plain, 128'd0);
  endtask

  logic [127:0] k1, ct1, pt1, pt2, ct2, k2, ct3, pt3;

  initial begin
    k1  = 128'h000102030405060708090a0b0c0d0e0f;
    ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt1 = 128'h00112233445566778899aabbccddeeff;
    pt2 = 128'hffeeddccbbaa99887766554433221100;
    k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct3 = 128'h3925841d02dc09fbdc118597196a0b32;
    pt3 = 128'h3243f6a8885a308d313198a2e0370734;
    build_sbox();
    ct2 = aes_enc(k1, pt2);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cypher    = '0;
    input_key = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle");

    // Cold cache.
    send(k1, ct1, pt1, 21);
    collect(0);

    // Same key hit; bus changes and an in_valid pulse mid-round must be ignored.
    send(k1, ct2, pt2, 11);
    repeat (4) @(negedge clk);
    in_valid  = 1'b1;
    cypher    = {$urandom, $urandom, $urandom, $urandom};
    input_key = k2;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    collect(0);

    // Key switch and back.
    send(k2, ct3, pt3, 21);
    collect(0);
    send(k1, ct1, pt1, 21);
    collect(0);

    // Backpressure on a hit.
    send(k1, ct2, pt2, 11);
    collect(7);

    // Reset while in ROUND with counter 5 (after edge T+5 of a hit).
    send(k1, ct1, pt1, 11);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {127'd0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    void'(sb.pop_front());
    @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Cache was cleared by reset, so this must miss.
    send(k1, ct1, pt1, 21);
    collect(0);
    send(k1, ct2, pt2, 11);
    collect(0);

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
